// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: opcode encodings, sequencer states and
// the default condition-flag latency.
package cpu_ctrl_pkg;

    localparam logic [1:0] OP_BR  = 2'b00;
    localparam logic [1:0] OP_JR  = 2'b01;
    localparam logic [1:0] OP_JAL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Cycles from the CON_In edge until the registered condition flag is valid.
    localparam int CON_LAT_DEF = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EVAL,
        ST_WAIT,
        ST_ADDR_Y,
        ST_ADDR_C,
        ST_ADDR_PC,
        ST_LINK,
        ST_JUMP,
        ST_DONE
    } branch_state_t;

endpackage

// File: rtl/con_wait_timer.sv
// Wait timer for the condition flip-flop: loaded with CON_LAT-1 when the
// sequencer leaves EVAL, counts down during WAIT, flags the last WAIT cycle.
module con_wait_timer #(
    parameter int CON_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Countdown register; a load always wins over a decrement.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cnt <= '0;
        end else if (load) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            cnt <= CNT_W'(CON_LAT - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // The count is 1 in the final WAIT cycle; WAIT leaves on that cycle.
    assign expired = (cnt <= CNT_W'(1));

endmodule

// File: rtl/branch_seq.sv
// Control-transfer sequencer (br / jr / jal) for the single-bus datapath.
// Moore strobes decoded from state; taken/illegal registered and valid in DONE.
module branch_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int CON_LAT = CON_LAT_DEF,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       con_flag,
    output logic       busy,
    output logic       done,
    output logic       taken,
    output logic       illegal,
    output logic       Gra,
    output logic       Rout,
    output logic       Rin,
    output logic       link_sel,
    output logic       CON_In,
    output logic       PCout,
    output logic       PCin,
    output logic       Yin,
    output logic       Cout,
    output logic       alu_add,
    output logic       Zin,
    output logic       Zlowout
);

    branch_state_t state, state_nxt;
    logic          taken_r, taken_nxt;
    logic          illegal_r, illegal_nxt;
    logic          wait_expired;

    con_wait_timer #(
        .CON_LAT (CON_LAT),
        .CNT_W   (CNT_W)
    ) u_con_wait_timer (
        .clk     (clk),
        .clear   (clear),
        .load    (state == ST_EVAL),
        .dec     (state == ST_WAIT),
        .expired (wait_expired)
    );

    // State and result-flag registers; reset drops everything to IDLE at once.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= ST_IDLE;
            taken_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            taken_r   <= taken_nxt;
            illegal_r <= illegal_nxt;
        end
    end

    // Next-state and result-flag logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_nxt   = state;
        taken_nxt   = taken_r;
        illegal_nxt = illegal_r;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    taken_nxt   = 1'b0;
                    illegal_nxt = (op == OP_ILL);
                    unique case (op)
                        OP_BR:   state_nxt = ST_EVAL;
                        OP_JR:   state_nxt = ST_JUMP;
                        OP_JAL:  state_nxt = ST_LINK;
                        default: state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_EVAL:    state_nxt = (CON_LAT <= 1) ? ST_ADDR_Y : ST_WAIT;
            ST_WAIT:    if (wait_expired) state_nxt = ST_ADDR_Y;
            // The only state in which the condition flag is consulted.
            ST_ADDR_Y:  state_nxt = con_flag ? ST_ADDR_C : ST_DONE;
            ST_ADDR_C:  state_nxt = ST_ADDR_PC;
            ST_ADDR_PC: begin
                state_nxt = ST_DONE;
                taken_nxt = 1'b1;
            end
            ST_LINK:    state_nxt = ST_JUMP;
            ST_JUMP: begin
                state_nxt = ST_DONE;
                taken_nxt = 1'b1;
            end
            ST_DONE: begin
                state_nxt   = ST_IDLE;
                taken_nxt   = 1'b0;
                illegal_nxt = 1'b0;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Moore datapath strobes decoded from state only.
    always_comb begin
        Gra      = 1'b0;
        Rout     = 1'b0;
        Rin      = 1'b0;
        link_sel = 1'b0;
        CON_In   = 1'b0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        Yin      = 1'b0;
        Cout     = 1'b0;
        alu_add  = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        unique case (state)
            ST_EVAL: begin
                Gra    = 1'b1;
                Rout   = 1'b1;
                CON_In = 1'b1;
            end
            ST_ADDR_Y: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            ST_ADDR_C: begin
                Cout    = 1'b1;
                alu_add = 1'b1;
                Zin     = 1'b1;
            end
            ST_ADDR_PC: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
            end
            ST_LINK: begin
                PCout    = 1'b1;
                link_sel = 1'b1;
                Rin      = 1'b1;
            end
            ST_JUMP: begin
                Gra  = 1'b1;
                Rout = 1'b1;
                PCin = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign taken   = taken_r;
    assign illegal = illegal_r;

endmodule
